// File: rtl/sync_fifo_pkg.sv
// Shared sizing and parameter-legality helpers for the synchronous FIFO.
package sync_fifo_pkg;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    // Thresholds are margins from the full/empty boundary and must leave both flags reachable.
    function automatic bit thr_legal(input int thr, input int asize);
        return (thr >= 1) && (thr <= fifo_depth(asize) - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage for sync_fifo with either fall-through or registered read.
module sync_fifo_mem #(
    parameter int DSIZE          = 8,
    parameter int ASIZE          = 4,
    parameter bit FALLTHROUGH_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic             i_re,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);
    logic [DSIZE-1:0] r_mem [2**ASIZE];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    generate
        if (FALLTHROUGH_EN) begin : g_ft
            assign o_rdata = r_mem[i_raddr];
        end else begin : g_reg
            logic [DSIZE-1:0] r_rdata;
            always_ff @(posedge clk) begin
                if (!rst_n)    r_rdata <= '0;
                else if (i_re) r_rdata <= r_mem[i_raddr];
            end
            assign o_rdata = r_rdata;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: binary pointers, registered occupancy flags, sticky error flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int    DSIZE           = 8,
    parameter int    ASIZE           = 4,
    parameter string FALLTHROUGH     = "TRUE",
    parameter int    FULL_THRESHOLD  = 1,
    parameter int    EMPTY_THRESHOLD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             almost_full,
    output logic             overflow_error,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             almost_empty,
    output logic             underflow_error,
    input  logic             err_clr,
    output logic [ASIZE:0]   count
);
    localparam int             DEPTH   = fifo_depth(ASIZE);
    localparam logic [ASIZE:0] DEPTH_V = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_LVL  = (ASIZE+1)'(DEPTH - FULL_THRESHOLD);
    localparam logic [ASIZE:0] AE_LVL  = (ASIZE+1)'(EMPTY_THRESHOLD);
    localparam logic [ASIZE:0] ONE     = (ASIZE+1)'(1);
    localparam bit             FT_EN   = (FALLTHROUGH == "TRUE");

    generate
        if (ASIZE < 1 || DSIZE < 1) begin : g_bad_size
            $error("sync_fifo: ASIZE and DSIZE must be at least 1");
        end
        if (!thr_legal(FULL_THRESHOLD, ASIZE)) begin : g_bad_full_thr
            $error("sync_fifo: FULL_THRESHOLD must be in 1..DEPTH-1");
        end
        if (!thr_legal(EMPTY_THRESHOLD, ASIZE)) begin : g_bad_empty_thr
            $error("sync_fifo: EMPTY_THRESHOLD must be in 1..DEPTH-1");
        end
    endgenerate

    logic [ASIZE:0] r_wbin, r_rbin, r_count, w_count_nxt;
    logic           r_full, r_afull, r_empty, r_aempty, r_ovf, r_unf;
    logic           w_wacc, w_racc;

    // Flush suppresses both accepts so neither memory nor the read register moves.
    assign w_wacc      = winc & ~r_full  & ~flush;
    assign w_racc      = rinc & ~r_empty & ~flush;
    assign w_count_nxt = r_count + (w_wacc ? ONE : '0) - (w_racc ? ONE : '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wbin   <= '0;
            r_rbin   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else begin
            if (w_wacc) r_wbin <= r_wbin + ONE;
            if (w_racc) r_rbin <= r_rbin + ONE;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == DEPTH_V);
            r_afull  <= (w_count_nxt >= AF_LVL);
            r_empty  <= (w_count_nxt == '0);
            r_aempty <= (w_count_nxt <= AE_LVL);
        end
    end

    // A new error event outranks a same-cycle clear; flush leaves the flags alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!flush) begin
            r_ovf <= (winc & r_full)  | (r_ovf & ~err_clr);
            r_unf <= (rinc & r_empty) | (r_unf & ~err_clr);
        end
    end

    sync_fifo_mem #(
        .DSIZE          (DSIZE),
        .ASIZE          (ASIZE),
        .FALLTHROUGH_EN (FT_EN)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wacc),
        .i_waddr (r_wbin[ASIZE-1:0]),
        .i_wdata (wdata),
        .i_re    (w_racc),
        .i_raddr (r_rbin[ASIZE-1:0]),
        .o_rdata (rdata)
    );

    assign wfull           = r_full;
    assign almost_full     = r_afull;
    assign rempty          = r_empty;
    assign almost_empty    = r_aempty;
    assign overflow_error  = r_ovf;
    assign underflow_error = r_unf;
    assign count           = r_count;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: fall-through FIFO for the main scenarios, registered-read FIFO for read latency.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst_n, flush, winc, rinc, err_clr;
    logic [7:0] wdata;
    logic       wfull, almost_full, overflow_error, rempty, almost_empty, underflow_error;
    logic [7:0] rdata;
    logic [4:0] count;

    logic       winc2, rinc2;
    logic [7:0] wdata2, rdata2;
    logic       wfull2, af2, ovf2, rempty2, ae2, unf2;
    logic [4:0] count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("TRUE"),
                .FULL_THRESHOLD(2), .EMPTY_THRESHOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
        .wfull(wfull), .almost_full(almost_full), .overflow_error(overflow_error),
        .rinc(rinc), .rdata(rdata), .rempty(rempty), .almost_empty(almost_empty),
        .underflow_error(underflow_error), .err_clr(err_clr), .count(count));

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("FALSE"),
                .FULL_THRESHOLD(2), .EMPTY_THRESHOLD(2)) dut_reg (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .winc(winc2), .wdata(wdata2),
        .wfull(wfull2), .almost_full(af2), .overflow_error(ovf2),
        .rinc(rinc2), .rdata(rdata2), .rempty(rempty2), .almost_empty(ae2),
        .underflow_error(unf2), .err_clr(1'b0), .count(count2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        winc = 0; rinc = 0; flush = 0; err_clr = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},  32'(count), 0);
        chk({tag, "_rempty"}, 32'(rempty), 1);
        chk({tag, "_aempty"}, 32'(almost_empty), 1);
        chk({tag, "_wfull"},  32'(wfull), 0);
        chk({tag, "_afull"},  32'(almost_full), 0);
        chk({tag, "_ovf"},    32'(overflow_error), 0);
        chk({tag, "_unf"},    32'(underflow_error), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; idle(); wdata = 0;
        winc2 = 0; rinc2 = 0; wdata2 = 0;
        step(); step();
        chk_reset_state("rst");
        chk("rst_rdata_reg", 32'(rdata2), 0);
        rst_n = 1;

        // Fill with 0x00..0x0F on consecutive cycles.
        for (int i = 0; i < 16; i++) begin
            winc = 1; wdata = 8'(i);
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), (i + 1 >= 14) ? 1 : 0);
        end
        idle();
        chk("fill_wfull", 32'(wfull), 1);
        chk("fill_head", 32'(rdata), 8'h00);

        // Full: simultaneous write/read accepts only the read.
        winc = 1; rinc = 1; wdata = 8'hEE;
        step(); idle();
        chk("ovf_count", 32'(count), 15);
        chk("ovf_wfull", 32'(wfull), 0);
        chk("ovf_flag", 32'(overflow_error), 1);
        err_clr = 1;
        step(); idle();
        chk("ovf_clr", 32'(overflow_error), 0);

        for (int k = 1; k < 16; k++) begin
            chk("drain_data", 32'(rdata), 32'(k));
            rinc = 1;
            step();
            chk("drain_aempty", 32'(almost_empty), (15 - k <= 2) ? 1 : 0);
        end
        idle();
        chk("drain_rempty", 32'(rempty), 1);
        chk("drain_count", 32'(count), 0);

        // Empty: lone read flags underflow and changes nothing else.
        rinc = 1;
        step(); idle();
        chk("unf_flag", 32'(underflow_error), 1);
        chk("unf_count", 32'(count), 0);
        chk("unf_rempty", 32'(rempty), 1);
        err_clr = 1;
        step(); idle();
        chk("unf_clr", 32'(underflow_error), 0);

        // Empty: simultaneous write/read accepts only the write.
        winc = 1; rinc = 1; wdata = 8'h77;
        step(); idle();
        chk("ewr_count", 32'(count), 1);
        chk("ewr_unf", 32'(underflow_error), 1);
        chk("ewr_rdata", 32'(rdata), 8'h77);
        rinc = 1; err_clr = 1;
        step(); idle();
        chk("ewr_drain", 32'(count), 0);
        chk("ewr_unf_clr", 32'(underflow_error), 0);

        // Steady-state streaming at occupancy 8 across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            winc = 1; wdata = 8'(8'h20 + i);
            step();
        end
        idle();
        chk("stream_fill", 32'(count), 8);
        for (int i = 0; i < 20; i++) begin
            chk("stream_data", 32'(rdata), 32'(8'h20 + i));
            winc = 1; rinc = 1; wdata = 8'(8'h28 + i);
            step();
            chk("stream_count", 32'(count), 8);
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            chk("stream_tail", 32'(rdata), 32'(8'h34 + i));
            rinc = 1;
            step();
        end
        idle();
        chk("stream_empty", 32'(rempty), 1);

        // Fill, then overflow with a same-cycle clear: the set wins.
        for (int i = 0; i < 16; i++) begin
            winc = 1; wdata = 8'(8'h40 + i);
            step();
        end
        winc = 1; err_clr = 1; wdata = 8'hFF;
        step(); idle();
        chk("setclr_ovf", 32'(overflow_error), 1);
        chk("setclr_count", 32'(count), 16);
        for (int i = 0; i < 6; i++) begin
            chk("pre_flush_data", 32'(rdata), 32'(8'h40 + i));
            rinc = 1;
            step();
        end
        idle();
        chk("pre_flush_count", 32'(count), 10);

        flush = 1; winc = 1; rinc = 1; wdata = 8'h99;
        step(); idle();
        chk("flush_count", 32'(count), 0);
        chk("flush_rempty", 32'(rempty), 1);
        chk("flush_aempty", 32'(almost_empty), 1);
        chk("flush_wfull", 32'(wfull), 0);
        chk("flush_afull", 32'(almost_full), 0);
        chk("flush_ovf", 32'(overflow_error), 1);

        for (int i = 0; i < 5; i++) begin
            winc = 1; wdata = 8'(8'h60 + i);
            step();
        end
        idle();
        chk("post_flush_count", 32'(count), 5);
        chk("post_flush_head", 32'(rdata), 8'h60);

        // Reset outranks a concurrent write.
        rst_n = 0; winc = 1; wdata = 8'h11;
        step(); idle();
        chk_reset_state("rst2");
        rst_n = 1;

        // Read latency: fall-through shows data after the write edge; registered needs a read.
        winc = 1; wdata = 8'hA5; winc2 = 1; wdata2 = 8'hA5;
        step(); idle(); winc2 = 0;
        chk("ft_rdata", 32'(rdata), 8'hA5);
        chk("reg_rdata_hold", 32'(rdata2), 0);
        chk("reg_count", 32'(count2), 1);
        rinc2 = 1;
        step(); rinc2 = 0;
        chk("reg_rdata", 32'(rdata2), 8'hA5);
        chk("reg_empty", 32'(rempty2), 1);
        chk("ft_rdata_hold", 32'(rdata), 8'hA5);
        step();
        chk("reg_rdata_keep", 32'(rdata2), 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DSIZE, default 8: data word width in bits.
REQ-002 Parameter ASIZE, default 4: address width; DEPTH = 2**ASIZE entries.
REQ-003 Parameter FALLTHROUGH, default "TRUE": "TRUE" gives first-word fall-through read; any other value gives a registered read.
REQ-004 Parameter FULL_THRESHOLD, default 1: almost_full margin, legal range 1..DEPTH-1.
REQ-005 Parameter EMPTY_THRESHOLD, default 1: almost_empty margin, legal range 1..DEPTH-1.
REQ-006 clk  input  1  the single clock; all logic is on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 flush  input  1  synchronous clear of contents; memory array is untouched.
REQ-009 winc  input  1  write request.
REQ-010 wdata  input  DSIZE  write data.
REQ-011 wfull  output  1  FIFO holds DEPTH entries.
REQ-012 almost_full  output  1  count >= DEPTH-FULL_THRESHOLD.
REQ-013 overflow_error  output  1  sticky: a write was attempted while full.
REQ-014 rinc  input  1  read request.
REQ-015 rdata  output  DSIZE  read data.
REQ-016 rempty  output  1  FIFO holds 0 entries.
REQ-017 almost_empty  output  1  count <= EMPTY_THRESHOLD.
REQ-018 underflow_error  output  1  sticky: a read was attempted while empty.
REQ-019 err_clr  input  1  clears both sticky error flags.
REQ-020 count  output  ASIZE+1  current occupancy, range 0..DEPTH.

Function
REQ-021 Write accept is wacc = winc & !wfull; read accept is racc = rinc & !rempty; both use the registered flags from the current cycle.
REQ-022 Pointers wbin and rbin are ASIZE+1-bit binary; the low ASIZE bits address memory; each wraps modulo 2**(ASIZE+1).
REQ-023 count, wfull, rempty, almost_full and almost_empty are registered and computed from next-state occupancy, so they are valid in the cycle after the accepting edge.
REQ-024 Next occupancy is count + wacc - racc. When wacc and racc are both set in one cycle, count is unchanged.
REQ-025 When full, a simultaneous winc and rinc accepts only the read. The write is dropped and sets overflow_error.
REQ-026 When empty, a simultaneous winc and rinc accepts only the write. The read sets underflow_error. The fall-through data does not bypass memory.
REQ-027 overflow_error sets on the edge after winc & wfull. underflow_error sets on the edge after rinc & rempty. Both hold until err_clr or reset. A set and an err_clr in the same cycle leave the flag set.
REQ-028 With FALLTHROUGH="TRUE", rdata = mem[rbin[ASIZE-1:0]] combinationally. The head word is visible while !rempty, and racc advances to the next word.
REQ-029 With a registered read, rdata loads mem[raddr] on the racc edge (latency 1) and holds otherwise.
REQ-030 flush, when no reset is active, on the next edge: pointers and count go to 0, rempty=1, almost_empty=1, wfull=0, almost_full=0. winc and rinc in the same cycle are ignored. Error flags are unchanged.
REQ-031 Memory writes occur only on wacc; there is no memory reset.

Reset
REQ-032 On an edge with rst_n=0: pointers=0, count=0, wfull=0, almost_full=0, rempty=1, almost_empty=1, both error flags=0, registered rdata=0.
REQ-033 Reset mid-operation discards all contents. Reset has priority over flush, err_clr, winc and rinc.

Structure
REQ-034 A shared package sync_fifo_pkg holds the DEPTH computation and the parameter-legality checks. The threshold range checks are elaboration-time errors.
REQ-035 Storage is one sub-module, sync_fifo_mem: a dual-port array plus the FALLTHROUGH generate. Pointer, flag and error logic stay in sync_fifo.

Verification
REQ-036 Use DSIZE=8, ASIZE=4, thresholds 2. After reset, write 0x00..0x0F on 16 consecutive cycles:
- count=16 and wfull=1 after the 16th edge;
- almost_full=1 from count=14 onward;
- all 16 values read back in order.
REQ-037 Full FIFO, winc=1 and rinc=1 for one cycle: count=15, wfull=0, overflow_error=1; err_clr pulse -> overflow_error=0.
REQ-038 Empty FIFO, rinc=1 for one cycle: underflow_error=1, count stays 0, rempty stays 1.
REQ-039 Fill to 8 entries, then 20 cycles of simultaneous winc and rinc: count stays 8, pointers wrap past 31, data order is preserved.
REQ-040 With FALLTHROUGH="FALSE", write 0xA5, then rinc: rdata=0xA5 one edge after racc; with "TRUE", rdata=0xA5 in the cycle after the write edge, with no rinc.
REQ-041 Flush at count=10 with sticky overflow set: count=0, rempty=1, overflow_error still 1. Then rst_n=0 at count=5: all outputs at their reset values.
